// File: rtl/axis_adc_stream.sv
// ADC / ramp-pattern capture into a small sample FIFO, streamed out as a
// 16-bit AXI4-Stream master with TLAST on every PKT_LEN-th beat.
module axis_adc_stream #(
   parameter int FIFO_DEPTH = 16,
   parameter int PKT_LEN    = 64,
   parameter int ADC_WIDTH  = 14
) (
   input  logic                        m_axis_aclk,
   input  logic                        m_axis_areset,
   input  logic [ADC_WIDTH-1:0]        adc_data,
   input  logic                        adc_valid,
   input  logic                        test_mode,
   output logic [15:0]                 m_axis_tdata,
   output logic [1:0]                  m_axis_tstrb,
   output logic [1:0]                  m_axis_tkeep,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(PKT_LEN);

   logic [ADC_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_r;
   logic [AW-1:0]        rd_ptr_r;
   logic [LW-1:0]        count_r;
   logic [ADC_WIDTH-1:0] ramp_r;
   logic [CW-1:0]        beat_r;
   logic [15:0]          tdata_r;
   logic                 tvalid_r;
   logic                 tlast_r;
   logic                 overflow_r;

   logic                 full_s;
   logic                 empty_s;
   logic                 wr_en_s;
   logic                 pop_s;
   logic                 hs_s;
   logic [ADC_WIDTH-1:0] sample_s;
   logic [CW-1:0]        next_beat_s;
   logic                 next_last_s;

   // FIFO status, capture/pop decisions and packet position of the next loaded beat
   always_comb begin
      full_s      = (count_r == LW'(FIFO_DEPTH));
      empty_s     = (count_r == {LW{1'b0}});
      sample_s    = test_mode ? ramp_r : adc_data;
      wr_en_s     = adc_valid && !full_s;
      hs_s        = tvalid_r && m_axis_tready;
      pop_s       = !empty_s && (!tvalid_r || m_axis_tready);
      next_beat_s = beat_r;
      if (hs_s) begin
         if (beat_r == CW'(PKT_LEN - 1)) begin
            next_beat_s = {CW{1'b0}};
         end else begin
            next_beat_s = beat_r + CW'(1);
         end
      end else begin
         next_beat_s = beat_r;
      end
      // A beat loaded now is presented once the current beat (if any) retires
      next_last_s = (next_beat_s == CW'(PKT_LEN - 1));
   end

   // Sample storage; contents need no reset since pointers gate every read
   always_ff @(posedge m_axis_aclk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= sample_s;
      end
   end

   // Ramp, FIFO pointers/occupancy and sticky overflow
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset) begin
         ramp_r     <= {ADC_WIDTH{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {LW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (adc_valid) begin
            ramp_r <= ramp_r + ADC_WIDTH'(1);
         end
         if (adc_valid && full_s) begin
            overflow_r <= 1'b1;
         end
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({wr_en_s, pop_s})
            2'b10:   count_r <= count_r + LW'(1);
            2'b01:   count_r <= count_r - LW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Output beat register and packet beat counter
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset) begin
         tdata_r  <= 16'h0000;
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
         beat_r   <= {CW{1'b0}};
      end else begin
         beat_r <= next_beat_s;
         if (pop_s) begin
            tvalid_r <= 1'b1;
            tdata_r  <= 16'(mem_r[rd_ptr_r]);
            tlast_r  <= next_last_s;
         end else if (hs_s) begin
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
         end
      end
   end

   assign m_axis_tdata  = tdata_r;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tlast  = tlast_r;
   assign m_axis_tstrb  = 2'b11;
   assign m_axis_tkeep  = 2'b11;
   assign overflow      = overflow_r;
   assign fifo_level    = count_r;

endmodule

// File: tb/tb_axis_adc_stream.sv
// Directed self-checking bench for axis_adc_stream: ramp streaming, backpressure,
// overflow, pass-through mode and mid-packet reset.
module tb_axis_adc_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] adc_data = 14'h0000;
   logic        adc_valid = 1'b0;
   logic        test_mode = 1'b0;
   logic [15:0] tdata;
   logic [1:0]  tstrb;
   logic [1:0]  tkeep;
   logic        tvalid;
   logic        tready = 1'b0;
   logic        tlast;
   logic        overflow;
   logic [4:0]  fifo_level;

   int errors = 0;
   int checks = 0;

   logic [16:0] beats[$];
   logic        stalled = 1'b0;
   logic [16:0] held = 17'h0;
   logic [5:0]  lfsr = 6'h01;

   axis_adc_stream #(.FIFO_DEPTH(16), .PKT_LEN(64), .ADC_WIDTH(14)) dut (
      .m_axis_aclk  (clk),
      .m_axis_areset(rst),
      .adc_data     (adc_data),
      .adc_valid    (adc_valid),
      .test_mode    (test_mode),
      .m_axis_tdata (tdata),
      .m_axis_tstrb (tstrb),
      .m_axis_tkeep (tkeep),
      .m_axis_tvalid(tvalid),
      .m_axis_tready(tready),
      .m_axis_tlast (tlast),
      .overflow     (overflow),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      adc_valid = 1'b0;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      beats.delete();
   endtask

   task automatic check_stream(input string tag, input int n, input int last_mod);
      check({tag, "_count"}, beats.size(), n);
      for (int i = 0; i < n && i < beats.size(); i++) begin
         check({tag, "_data"}, beats[i][15:0], i);
         check({tag, "_last"}, beats[i][16], ((i % last_mod) == last_mod - 1) ? 1 : 0);
      end
   endtask

   // Collect accepted beats and verify hold-while-stalled
   always @(posedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", tvalid, 1);
            check("stall_hold", {tlast, tdata}, held);
         end
         if (tvalid && tready) beats.push_back({tlast, tdata});
         stalled = tvalid && !tready;
         held = {tlast, tdata};
      end
   end

   initial begin
      // Reset held while strobes arrive
      rst = 1'b1;
      test_mode = 1'b1;
      tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         adc_valid = 1'b1;
         cyc();
         check("rst_tvalid", tvalid, 0);
         check("rst_overflow", overflow, 0);
         check("rst_level", fifo_level, 0);
         check("rst_tdata", tdata, 0);
         check("tstrb", tstrb, 2'b11);
         check("tkeep", tkeep, 2'b11);
      end
      do_reset();

      // Ramp, 200 strobes every 3rd cycle, tready=1
      adc_valid = 1'b1;
      cyc();
      adc_valid = 1'b0;
      check("lat_before", tvalid, 0);
      check("lat_level", fifo_level, 1);
      cyc();
      check("lat_tvalid", tvalid, 1);
      check("lat_tdata", tdata, 0);
      cyc();
      for (int i = 1; i < 200; i++) begin
         adc_valid = 1'b1;
         cyc();
         adc_valid = 1'b0;
         cyc();
         cyc();
      end
      repeat (5) cyc();
      check_stream("ramp", 200, 64);
      check("ramp_idle", tvalid, 0);

      // Random backpressure from LFSR, strobe every 2nd cycle
      do_reset();
      for (int i = 0; i < 256; i++) begin
         adc_valid = 1'b1;
         tready = lfsr[0];
         lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
         cyc();
         adc_valid = 1'b0;
         tready = lfsr[0];
         lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
         cyc();
      end
      tready = 1'b1;
      repeat (30) cyc();
      check_stream("bp", 256, 64);
      check("bp_overflow", overflow, 0);

      // Overflow: 20 back-to-back strobes with no drain
      do_reset();
      tready = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         adc_valid = 1'b1;
         cyc();
         if (i == 17) check("ovf_17", overflow, 0);
         if (i == 18) check("ovf_18", overflow, 1);
      end
      adc_valid = 1'b0;
      check("ovf_level", fifo_level, 16);
      check("ovf_tvalid", tvalid, 1);
      check("ovf_tdata", tdata, 0);
      tready = 1'b1;
      repeat (25) cyc();
      check_stream("ovf", 17, 64);
      check("ovf_drained", tvalid, 0);
      check("ovf_sticky", overflow, 1);
      check("ovf_level0", fifo_level, 0);

      // Pass-through samples, ramp still advancing underneath
      do_reset();
      test_mode = 1'b0;
      adc_data = 14'h3FFF;
      adc_valid = 1'b1;
      cyc();
      adc_data = 14'h0001;
      cyc();
      test_mode = 1'b1;
      adc_data = 14'h1555;
      cyc();
      adc_valid = 1'b0;
      repeat (4) cyc();
      check("pt_count", beats.size(), 3);
      if (beats.size() == 3) begin
         check("pt_0", beats[0][15:0], 16'h3FFF);
         check("pt_1", beats[1][15:0], 16'h0001);
         check("pt_2", beats[2][15:0], 16'h0002);
      end

      // Reset mid-packet after 30 beats
      do_reset();
      for (int i = 0; i < 100 && beats.size() < 30; i++) begin
         adc_valid = 1'b1;
         cyc();
      end
      check("mid_beats", beats.size() >= 30 ? 1 : 0, 1);
      adc_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_tvalid", tvalid, 0);
      check("mid_level", fifo_level, 0);
      cyc();
      rst = 1'b0;
      beats.delete();
      for (int i = 0; i < 70; i++) begin
         adc_valid = 1'b1;
         cyc();
      end
      adc_valid = 1'b0;
      repeat (5) cyc();
      check_stream("mid", 70, 64);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_adc_stream.md
Name: axis_adc_stream

Overview:
- Captures 14-bit ADC samples, or an internal ramp test pattern, into a small FIFO.
- Emits the samples as a 16-bit AXI4-Stream master, with TLAST marking every PKT_LEN-th beat.
- Sits between the ADC front end and downstream AXIS consumers (DMA, packetiser).
- Single clock domain; the ADC strobe is already synchronous to m_axis_aclk.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries; power of two, >= 2.
- PKT_LEN, 64, beats per packet; TLAST on the last beat; >= 2.
- ADC_WIDTH, 14, sample width; zero-extended to 16-bit TDATA; <= 16.

Ports:
- m_axis_aclk  in  1  sole clock; all logic on its rising edge.
- m_axis_areset  in  1  asynchronous, active-high reset.
- adc_data  in  ADC_WIDTH  ADC sample; valid when adc_valid=1.
- adc_valid  in  1  one-cycle sample strobe.
- test_mode  in  1  1 = capture internal ramp instead of adc_data.
- m_axis_tdata  out  16  {zeros, sample}.
- m_axis_tstrb  out  2  constant 2'b11.
- m_axis_tkeep  out  2  constant 2'b11.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held in the FIFO, excluding the output register.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: tvalid=0, tlast=0, tdata=0, overflow=0, fifo_level=0.
  - Internal state: ramp=0, beat counter=0, FIFO pointers cleared.
  - Reset mid-packet discards all buffered samples; the next packet starts at beat 0.
- Ramp generator:
  - ADC_WIDTH-bit counter, incremented by 1 on every cycle with adc_valid=1, regardless of test_mode.
  - Wraps from 2^ADC_WIDTH-1 to 0.
- Capture on a rising edge with adc_valid=1:
  - Captured sample = test_mode ? ramp (value before increment) : adc_data.
  - If FIFO not full: write the sample.
  - If FIFO full: drop the sample and set overflow=1.
  - Full is evaluated on registered state: a pop in the same cycle does not free space for that cycle's write.
  - overflow clears only on reset.
- Output stage:
  - One output register (tdata/tlast/tvalid) fed by the FIFO.
  - It loads when (tvalid=0 or tready=1) and the FIFO is non-empty.
  - It clears tvalid when a handshake occurs and the FIFO is empty.
  - Latency: sample captured at edge N with FIFO and output empty gives tvalid=1 after edge N+1.
  - Sustained throughput is 1 beat/cycle while the FIFO is non-empty and tready=1.
- AXIS rules:
  - Once tvalid=1, tdata and tlast hold stable until a handshake (tvalid & tready).
  - tvalid never depends combinationally on tready.
  - No beat is duplicated or reordered; samples appear in capture order.
- Packetisation:
  - Beat counter 0..PKT_LEN-1 advances on each handshake and wraps to 0.
  - tlast=1 on the beat presented when counter = PKT_LEN-1; beats 64, 128, ... with defaults.
  - tlast is computed when the beat is loaded into the output register.
- fifo_level:
  - +1 on an accepted write, -1 on a pop; unchanged on a simultaneous accepted write and pop.

Test Plan:
- Reset then idle: assert m_axis_areset while adc_valid pulses -> tvalid=0, overflow=0, fifo_level=0 throughout; tstrb=tkeep=2'b11.
- Ramp, tready=1: test_mode=1, adc_valid every 3rd cycle for 200 strobes -> tdata 0,1,2,...,199 in order; tlast only on tdata=63,127,191; first tvalid 1 cycle after first capture.
- Random backpressure: tready driven by a 6-bit LFSR bit, adc_valid every 2nd cycle -> every accepted beat = previous+1; tdata/tlast stable while tvalid&!tready; tlast on every 64th accepted beat (tdata%64=63); no overflow.
- Overflow: tready=0, adc_valid every cycle for 20 cycles with defaults -> 16 FIFO + 1 output register held; overflow=1 after the 18th strobe. Release tready -> 17 beats with tdata 0..16, then tvalid=0; overflow stays 1.
- Pass-through mode: test_mode=0, adc_data=14'h3FFF then 14'h0001 -> tdata 16'h3FFF then 16'h0001; ramp still advances (switch to test_mode=1 -> next tdata=2).
- Reset mid-packet: after 30 beats, pulse m_axis_areset -> tvalid=0 immediately. Next packet restarts the ramp at 0, and tlast falls on its 64th beat.
